// File: rtl/conv1d_ctrl_regs.sv
// conv1d_ctrl_regs: control/status register responder for the conv1d accelerator.
// reg_req_i = {valid, write, wstrb[3:0], addr[31:0], wdata[31:0]}; reg_rsp_o = {error, ready, rdata[31:0]}.
// Optional busy-cycle counter at 0x1C is built when CONV1D_REGS_PERF_EN is defined.
module conv1d_ctrl_regs #(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [69:0]          reg_req_i,
    output logic [33:0]          reg_rsp_o,
    output logic                 start_o,
    output logic                 clr_o,
    input  logic                 done_i,
    output logic [31:0]          src_addr_o,
    output logic [31:0]          dst_addr_o,
    output logic [LEN_WIDTH-1:0] in_len_o,
    output logic [LEN_WIDTH-1:0] ker_len_o,
    output logic                 irq_o
);

    localparam logic [7:0] OFF_CTRL    = 8'h00;
    localparam logic [7:0] OFF_STATUS  = 8'h04;
    localparam logic [7:0] OFF_SRC     = 8'h08;
    localparam logic [7:0] OFF_DST     = 8'h0C;
    localparam logic [7:0] OFF_IN_LEN  = 8'h10;
    localparam logic [7:0] OFF_KER_LEN = 8'h14;
    localparam logic [7:0] OFF_IRQ_EN  = 8'h18;
`ifdef CONV1D_REGS_PERF_EN
    localparam logic [7:0] OFF_PERF    = 8'h1C;
`endif

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

    state_t                state_r;
    logic                  ready_r;
    logic                  err_r;
    logic [31:0]           rdata_r;
    logic                  start_r;
    logic                  clr_r;
    logic [31:0]           src_addr_r;
    logic [31:0]           dst_addr_r;
    logic [LEN_WIDTH-1:0]  in_len_r;
    logic [LEN_WIDTH-1:0]  ker_len_r;
    logic                  irq_en_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  irq_r;

    logic                  req_valid_s;
    logic                  req_write_s;
    logic [3:0]            req_wstrb_s;
    logic [7:0]            req_offset_s;
    logic [31:0]           req_wdata_s;
    logic                  unused_addr_s;
    logic                  access_s;
    logic                  start_bad_s;

    logic                  err_s;
    logic [31:0]           rdata_s;
    logic                  start_req_s;
    logic                  clr_req_s;
    logic                  w1c_s;
    logic                  src_we_s;
    logic                  dst_we_s;
    logic                  in_len_we_s;
    logic                  ker_len_we_s;
    logic                  irq_en_we_s;
    logic                  busy_n_s;
    logic                  done_n_s;
    logic                  irq_en_n_s;

    assign req_valid_s   = reg_req_i[69];
    assign req_write_s   = reg_req_i[68];
    assign req_wstrb_s   = reg_req_i[67:64];
    assign req_offset_s  = reg_req_i[39:32];
    assign req_wdata_s   = reg_req_i[31:0];
    assign unused_addr_s = ^reg_req_i[63:40];

    assign access_s    = (state_r == ST_IDLE) && req_valid_s;
    assign start_bad_s = busy_r
                         || (in_len_r == {LEN_WIDTH{1'b0}})
                         || (ker_len_r == {LEN_WIDTH{1'b0}})
                         || (ker_len_r > in_len_r);

`ifdef CONV1D_REGS_PERF_EN
    logic [31:0] perf_cnt_r;

    // Busy-cycle counter: restarts on an accepted START, saturates at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cnt_r <= 32'h0000_0000;
        end else if (start_req_s) begin
            perf_cnt_r <= 32'h0000_0000;
        end else if (busy_r && (perf_cnt_r != 32'hFFFF_FFFF)) begin
            perf_cnt_r <= perf_cnt_r + 32'd1;
        end else begin
            perf_cnt_r <= perf_cnt_r;
        end
    end
`endif

    // Address decode: error classification, read data and per-register actions.
    always_comb begin
        err_s        = 1'b0;
        rdata_s      = 32'h0000_0000;
        start_req_s  = 1'b0;
        clr_req_s    = 1'b0;
        w1c_s        = 1'b0;
        src_we_s     = 1'b0;
        dst_we_s     = 1'b0;
        in_len_we_s  = 1'b0;
        ker_len_we_s = 1'b0;
        irq_en_we_s  = 1'b0;
        if (access_s) begin
            case (req_offset_s)
                OFF_CTRL: begin
                    if (req_write_s && req_wstrb_s[0]) begin
                        if (req_wdata_s[1]) begin
                            clr_req_s = 1'b1;
                        end else if (req_wdata_s[0]) begin
                            if (start_bad_s) begin
                                err_s = 1'b1;
                            end else begin
                                start_req_s = 1'b1;
                            end
                        end else begin
                            clr_req_s = 1'b0;
                        end
                    end else begin
                        rdata_s = 32'h0000_0000;
                    end
                end
                OFF_STATUS: begin
                    if (req_write_s) begin
                        // BUSY is read-only, so a write that sets bit0 is refused outright.
                        if (req_wstrb_s[0] && req_wdata_s[0]) begin
                            err_s = 1'b1;
                        end else begin
                            w1c_s = req_wstrb_s[0] && req_wdata_s[1];
                        end
                    end else begin
                        rdata_s = {30'h0, done_r, busy_r};
                    end
                end
                OFF_SRC: begin
                    if (req_write_s) begin
                        err_s    = busy_r;
                        src_we_s = !busy_r;
                    end else begin
                        rdata_s = src_addr_r;
                    end
                end
                OFF_DST: begin
                    if (req_write_s) begin
                        err_s    = busy_r;
                        dst_we_s = !busy_r;
                    end else begin
                        rdata_s = dst_addr_r;
                    end
                end
                OFF_IN_LEN: begin
                    if (req_write_s) begin
                        err_s       = busy_r;
                        in_len_we_s = !busy_r;
                    end else begin
                        rdata_s = 32'(in_len_r);
                    end
                end
                OFF_KER_LEN: begin
                    if (req_write_s) begin
                        err_s        = busy_r;
                        ker_len_we_s = !busy_r;
                    end else begin
                        rdata_s = 32'(ker_len_r);
                    end
                end
                OFF_IRQ_EN: begin
                    if (req_write_s) begin
                        irq_en_we_s = req_wstrb_s[0];
                    end else begin
                        rdata_s = {31'h0, irq_en_r};
                    end
                end
`ifdef CONV1D_REGS_PERF_EN
                OFF_PERF: begin
                    if (req_write_s) begin
                        err_s = 1'b1;
                    end else begin
                        rdata_s = perf_cnt_r;
                    end
                end
`endif
                default: begin
                    err_s = 1'b1;
                end
            endcase
        end else begin
            err_s = 1'b0;
        end
    end

    // Next BUSY/DONE: completion beats a same-cycle W1C, CLEAR beats everything.
    always_comb begin
        busy_n_s   = busy_r;
        done_n_s   = done_r;
        irq_en_n_s = irq_en_we_s ? req_wdata_s[0] : irq_en_r;
        if (w1c_s) begin
            done_n_s = 1'b0;
        end else begin
            done_n_s = done_r;
        end
        if (start_req_s) begin
            busy_n_s = 1'b1;
            done_n_s = 1'b0;
        end else begin
            busy_n_s = busy_n_s;
        end
        if (done_i && busy_r) begin
            busy_n_s = 1'b0;
            done_n_s = 1'b1;
        end else begin
            busy_n_s = busy_n_s;
        end
        if (clr_req_s) begin
            busy_n_s = 1'b0;
            done_n_s = 1'b0;
        end else begin
            done_n_s = done_n_s;
        end
    end

    // Bus handshake FSM with registered response and command pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 32'h0000_0000;
            start_r <= 1'b0;
            clr_r   <= 1'b0;
        end else begin
            start_r <= start_req_s;
            clr_r   <= clr_req_s;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid_s) begin
                        state_r <= ST_RESP;
                        ready_r <= 1'b1;
                        err_r   <= err_s;
                        rdata_r <= err_s ? 32'h0000_0000 : rdata_s;
                    end else begin
                        ready_r <= 1'b0;
                        err_r   <= 1'b0;
                        rdata_r <= 32'h0000_0000;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                    err_r   <= 1'b0;
                    rdata_r <= 32'h0000_0000;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                    err_r   <= 1'b0;
                    rdata_r <= 32'h0000_0000;
                end
            endcase
        end
    end

    // Configuration, status and interrupt registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_addr_r <= 32'h0000_0000;
            dst_addr_r <= 32'h0000_0000;
            in_len_r   <= {LEN_WIDTH{1'b0}};
            ker_len_r  <= {LEN_WIDTH{1'b0}};
            irq_en_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            if (src_we_s) begin
                src_addr_r <= merge_bytes(src_addr_r, req_wdata_s, req_wstrb_s);
            end else begin
                src_addr_r <= src_addr_r;
            end
            if (dst_we_s) begin
                dst_addr_r <= merge_bytes(dst_addr_r, req_wdata_s, req_wstrb_s);
            end else begin
                dst_addr_r <= dst_addr_r;
            end
            if (in_len_we_s) begin
                in_len_r <= LEN_WIDTH'(merge_bytes(32'(in_len_r), req_wdata_s, req_wstrb_s));
            end else begin
                in_len_r <= in_len_r;
            end
            if (ker_len_we_s) begin
                ker_len_r <= LEN_WIDTH'(merge_bytes(32'(ker_len_r), req_wdata_s, req_wstrb_s));
            end else begin
                ker_len_r <= ker_len_r;
            end
            irq_en_r <= irq_en_n_s;
            busy_r   <= busy_n_s;
            done_r   <= done_n_s;
            irq_r    <= done_n_s & irq_en_n_s;
        end
    end

    assign reg_rsp_o  = {err_r, ready_r, rdata_r};
    assign start_o    = start_r;
    assign clr_o      = clr_r;
    assign src_addr_o = src_addr_r;
    assign dst_addr_o = dst_addr_r;
    assign in_len_o   = in_len_r;
    assign ker_len_o  = ker_len_r;
    assign irq_o      = irq_r;

endmodule
